btn_conditioner: RTL and testbench

- Front-end conditioning stage for all board pushbuttons (up, left, right, down, power).
- Synchronises each raw pad, debounces it, and produces a clean level plus single-cycle rise, fall and long-press pulses.
- Feeds the mode/start logic and the manual, semi-auto and auto controllers, which consume pulses instead of raw pad levels.
- Runs on the 100 MHz board clock, ahead of any clock division.

---
 rtl/btn_pkg.sv | 29 ++
 rtl/btn_conditioner_channel.sv | 142 ++++++++++++++
 rtl/btn_conditioner.sv | 55 +++++
 tb/tb_btn_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the pushbutton conditioning front end.
//   - btn_state_e : per-channel debounce/hold state
//   - BTN_*       : bit positions of each board button in the btn_* vectors
//   - DEF_*       : default timing for the 100 MHz board clock
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_POWER = 4;

  localparam int DEF_N_BTN             = 5;
  localparam int DEF_DEBOUNCE_CYCLES   = 2000000;    // 20 ms at 100 MHz
  localparam int DEF_LONG_PRESS_CYCLES = 100000000;  // 1 s at 100 MHz
  localparam int DEF_CNT_W             = 27;

endpackage

// File: rtl/btn_conditioner_channel.sv
// -----------------------------------------------------------------------------
// btn_conditioner_channel
//   One pushbutton channel: 2-flop synchroniser, debounce FSM, hold counter.
//   Ports:
//     clk_i    board clock, rising edge
//     rst_ni   asynchronous active-low reset
//     raw_i    raw asynchronous pad level, 1 = pressed
//     level_o  debounced level
//     rise_o   1-cycle pulse on level 0->1
//     fall_o   1-cycle pulse on level 1->0
//     long_o   1-cycle pulse once per press after LONG_PRESS_CYCLES held
//     state_o  current FSM state (debug)
//   Handshake: none; all outputs are registered levels/pulses, no back-pressure.
// -----------------------------------------------------------------------------
module btn_conditioner_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raw_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       long_o,
  output btn_state_e state_o
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             long_flag_q;  // press already reached LONG_HELD
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             long_q;

  // Hold counter stops at the threshold so a release glitch straddling the
  // threshold still leaves it matching when the press resumes.
  logic [CNT_W-1:0] hcnt_inc;
  assign hcnt_inc = (hcnt_q < HOLD_MAX) ? hcnt_q + 1'b1 : hcnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= RELEASED;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (sync2_q) begin
            state_q <= PRESS_WAIT;
            dcnt_q  <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q) begin
            state_q <= RELEASED;
            dcnt_q  <= '0;
          end else if (dcnt_q >= DEB_MAX) begin
            state_q     <= PRESSED;
            level_q     <= 1'b1;
            rise_q      <= 1'b1;
            hcnt_q      <= '0;
            dcnt_q      <= '0;
            long_flag_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_q <= RELEASE_WAIT;
            dcnt_q  <= CNT_W'(1);
            hcnt_q  <= hcnt_inc;
          end else if (hcnt_q == HOLD_MAX) begin
            state_q     <= LONG_HELD;
            long_q      <= 1'b1;
            long_flag_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_inc;
          end
        end
        LONG_HELD: begin
          if (!sync2_q) begin
            state_q <= RELEASE_WAIT;
            dcnt_q  <= CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          // Glitch time keeps counting toward the hold threshold.
          if (!long_flag_q) hcnt_q <= hcnt_inc;
          if (sync2_q) begin
            state_q <= long_flag_q ? LONG_HELD : PRESSED;
            dcnt_q  <= '0;
          end else if (dcnt_q >= DEB_MAX) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
          level_q <= 1'b0;
          dcnt_q  <= '0;
          hcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign long_o  = long_q;
  assign state_o = state_q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions all board pushbuttons: synchronise, debounce, and produce a
//   clean level plus single-cycle rise, fall and long-press pulses.
//   Ports:
//     clk        100 MHz board clock, rising edge
//     rst_n      asynchronous active-low reset
//     btn_raw    raw pad levels, 1 = pressed (index by BTN_* in btn_pkg)
//     btn_level  debounced level
//     btn_rise   1-cycle pulse on level 0->1
//     btn_fall   1-cycle pulse on level 1->0
//     btn_long   1-cycle pulse once per press after LONG_PRESS_CYCLES
//     btn_state  per-channel FSM state, 3 bits per channel (debug)
//   Handshake: none; consumers sample the registered pulses each cycle.
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN             = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_rise,
  output logic [N_BTN-1:0]   btn_fall,
  output logic [N_BTN-1:0]   btn_long,
  output logic [3*N_BTN-1:0] btn_state
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_state_e ch_state;

    btn_conditioner_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .CNT_W            (CNT_W)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .raw_i  (btn_raw[gi]),
      .level_o(btn_level[gi]),
      .rise_o (btn_rise[gi]),
      .fall_o (btn_fall[gi]),
      .long_o (btn_long[gi]),
      .state_o(ch_state)
    );

    assign btn_state[3*gi +: 3] = ch_state;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   btn_raw = '0;
  logic [N-1:0]   btn_level, btn_rise, btn_fall, btn_long;
  logic [3*N-1:0] btn_state;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .btn_long(btn_long), .btn_state(btn_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;
  logic [4*N-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on runs of synchronised samples: a press is accepted on the
  // (D+1)-th consecutive pressed sample, a release likewise; long fires on the
  // first steady pressed sample at least L-1 cycles after the rise cycle.
  int cyc = 0;
  bit ms1[N], ms2[N], lvl[N], long_done[N];
  int orun[N], zrun[N], rise_t[N];

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      ms1[i] = 0; ms2[i] = 0; lvl[i] = 0; long_done[i] = 0;
      orun[i] = 0; zrun[i] = 0; rise_t[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] lv, rs, fl, lg;
    bit s;
    lv = '0; rs = '0; fl = '0; lg = '0;
    for (int i = 0; i < N; i++) begin
      s = ms2[i];
      ms2[i] = ms1[i];
      ms1[i] = raw[i];
      if (!lvl[i]) begin
        if (s) begin
          orun[i]++;
          if (orun[i] == D + 1) begin
            lvl[i] = 1; rs[i] = 1; rise_t[i] = cyc;
            long_done[i] = 0; zrun[i] = 0; orun[i] = 0;
          end
        end else begin
          orun[i] = 0;
        end
      end else if (s) begin
        if (zrun[i] == 0 && !long_done[i] && (cyc - rise_t[i] - 1) >= L - 1) begin
          lg[i] = 1; long_done[i] = 1;
        end
        zrun[i] = 0;
      end else begin
        zrun[i]++;
        if (zrun[i] == D + 1) begin
          lvl[i] = 0; fl[i] = 1; zrun[i] = 0;
        end
      end
      lv[i] = lvl[i];
    end
    exp_q.push_back({lg, fl, rs, lv});
  endtask

  // ---------------- DUT event bookkeeping for directed checks ----------------
  int rise_cnt[N], fall_cnt[N], long_cnt[N];
  int first_rise[N], first_fall[N], first_long[N];

  task automatic reset_counts();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; long_cnt[i] = 0;
      first_rise[i] = -1; first_fall[i] = -1; first_long[i] = -1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] raw);
    logic [4*N-1:0] exp;
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    cyc++;
    model_edge(raw);
    #1;
    exp = exp_q.pop_front();
    check_eq($sformatf("out_cyc%0d", cyc), 32'({btn_long, btn_fall, btn_rise, btn_level}), 32'(exp));
    for (int i = 0; i < N; i++) begin
      if (btn_rise[i]) begin rise_cnt[i]++; if (first_rise[i] < 0) first_rise[i] = cyc; end
      if (btn_fall[i]) begin fall_cnt[i]++; if (first_fall[i] < 0) first_fall[i] = cyc; end
      if (btn_long[i]) begin long_cnt[i]++; if (first_long[i] < 0) first_long[i] = cyc; end
    end
  endtask

  task automatic run(input logic [N-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, and releases
  // it just after an edge so the next modelled edge is the first live one.
  task automatic do_reset(input logic [N-1:0] raw);
    rst_n   = 1'b0;
    btn_raw = raw;
    #1;
    check_eq("rst_outputs", 32'({btn_long, btn_fall, btn_rise, btn_level}), 32'd0);
    check_eq("rst_state", 32'(btn_state), 32'd0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_outputs", 32'({btn_long, btn_fall, btn_rise, btn_level}), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int c0, c1, c2;
  logic [N-1:0] cur;
  int remain[N];

  initial begin
    model_clear();
    reset_counts();
    #2;
    do_reset('0);

    // 1: clean press on BTN_UP
    reset_counts();
    c0 = cyc + 1;
    run(5'b00001 << BTN_UP, 12);
    check_eq("s1_rise_lat", 32'(first_rise[BTN_UP] - c0), 32'd6);
    check_eq("s1_rise_cnt", 32'(rise_cnt[BTN_UP]), 32'd1);
    check_eq("s1_other_rise", 32'(rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + rise_cnt[4]), 32'd0);
    run('0, 12);

    // 2: glitch rejection on BTN_LEFT
    reset_counts();
    run(5'b00001 << BTN_LEFT, 3);
    run('0, 20);
    check_eq("s2_rise_cnt", 32'(rise_cnt[BTN_LEFT]), 32'd0);
    check_eq("s2_fall_cnt", 32'(fall_cnt[BTN_LEFT]), 32'd0);

    // 3: long press on BTN_POWER
    reset_counts();
    c0 = cyc + 1;
    run(5'b00001 << BTN_POWER, 30);
    c1 = cyc + 1;
    run('0, 12);
    check_eq("s3_rise_lat", 32'(first_rise[BTN_POWER] - c0), 32'd6);
    check_eq("s3_long_lat", 32'(first_long[BTN_POWER] - c0), 32'd16);
    check_eq("s3_long_cnt", 32'(long_cnt[BTN_POWER]), 32'd1);
    check_eq("s3_fall_lat", 32'(first_fall[BTN_POWER] - c1), 32'd6);

    // 4: short release glitch while pressed on BTN_RIGHT
    reset_counts();
    run(5'b00001 << BTN_RIGHT, 12);
    run('0, 2);
    run(5'b00001 << BTN_RIGHT, 10);
    check_eq("s4_level", 32'(btn_level[BTN_RIGHT]), 32'd1);
    check_eq("s4_fall_cnt", 32'(fall_cnt[BTN_RIGHT]), 32'd0);
    check_eq("s4_rise_cnt", 32'(rise_cnt[BTN_RIGHT]), 32'd1);
    run('0, 12);
    check_eq("s4_final_fall", 32'(fall_cnt[BTN_RIGHT]), 32'd1);

    // 5: asynchronous reset mid-hold, button kept pressed
    run(5'b00001 << BTN_UP, 12);
    do_reset(5'b00001 << BTN_UP);
    reset_counts();
    c0 = cyc + 1;
    run(5'b00001 << BTN_UP, 10);
    check_eq("s5_rise_lat", 32'(first_rise[BTN_UP] - c0), 32'd6);
    check_eq("s5_rise_cnt", 32'(rise_cnt[BTN_UP]), 32'd1);
    run('0, 12);

    // 6: simultaneous presses, staggered releases
    reset_counts();
    c0 = cyc + 1;
    run((5'b00001 << BTN_UP) | (5'b00001 << BTN_DOWN), 10);
    c1 = cyc + 1;
    run(5'b00001 << BTN_DOWN, 8);
    c2 = cyc + 1;
    run('0, 12);
    check_eq("s6_rise_up", 32'(first_rise[BTN_UP] - c0), 32'd6);
    check_eq("s6_rise_down", 32'(first_rise[BTN_DOWN] - c0), 32'd6);
    check_eq("s6_fall_up", 32'(first_fall[BTN_UP] - c1), 32'd6);
    check_eq("s6_fall_down", 32'(first_fall[BTN_DOWN] - c2), 32'd6);

    // Randomised runs of mixed length: glitches, normal and long presses.
    cur = '0;
    for (int i = 0; i < N; i++) remain[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (remain[i] == 0) begin
          cur[i] = ~cur[i];
          case ($urandom_range(0, 3))
            0:       remain[i] = $urandom_range(1, D + 1);
            1:       remain[i] = $urandom_range(L, 3 * L);
            default: remain[i] = $urandom_range(D + 1, 2 * L);
          endcase
        end
        remain[i]--;
      end
      step(cur);
      if (k == 1000 || k == 2200) do_reset(cur);
    end
    run('0, 12);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
